data_mem_responder: RTL and testbench

- Byte-addressed data memory that serves load/store requests issued by the MEM stage.
- Request signals are mem_enable, mem_rw, mem_size and mem_se, the same fields carried in control word bits [0], [4], [6:5] and [3].
- Transfers one byte per cycle and holds busy so the pipeline can stall; pulses done when the access completes.
- Big-endian to match the instruction memory byte order. A bench preload port replaces hierarchical memory writes.

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-serial, big-endian data memory for the MEM stage: one byte per cycle,
// busy while transferring, done pulse on completion or on a rejected request.
module data_mem_responder #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              busy,
  output logic              done,
  output logic              misalign_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              rw_q, se_q;
  logic [31:0]       wdata_q, asm_q;
  logic [1:0]        cnt;

  logic [7:0] mem [DEPTH];

  logic [1:0]        last_idx, sel;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        rbyte, wbyte;
  logic [31:0]       assembled, ext;
  logic              legal;

  // Index of the final byte (0/1/3); sel walks store bytes MSB first.
  assign last_idx  = {size_q[1], size_q[1] | size_q[0]};
  assign sel       = last_idx - cnt;
  assign acc_addr  = addr_q + ADDR_W'(cnt);
  assign rbyte     = mem[acc_addr];
  assign wbyte     = wdata_q[{sel, 3'b000} +: 8];
  assign assembled = {asm_q[23:0], rbyte};

  always_comb begin
    ext = assembled;
    case (size_q)
      2'b00:   ext = {{24{se_q & assembled[7]}},  assembled[7:0]};
      2'b01:   ext = {{16{se_q & assembled[15]}}, assembled[15:0]};
      default: ext = assembled;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (mem_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~address[0];
      2'b10:   legal = (address[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Array has no reset; reset only blocks writes on the aborting edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ACCESS && rw_q)
        mem[acc_addr] <= wbyte;
      else if (state == IDLE && !mem_enable && load_we)
        mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      data_out     <= 32'h0;
      cnt          <= 2'd0;
      asm_q        <= 32'h0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      rw_q         <= 1'b0;
      se_q         <= 1'b0;
      wdata_q      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done         <= 1'b0;
          misalign_err <= 1'b0;
          if (mem_enable) begin
            addr_q   <= address;
            size_q   <= mem_size;
            rw_q     <= mem_rw;
            se_q     <= mem_se;
            wdata_q  <= data_in;
            data_out <= 32'h0;
            cnt      <= 2'd0;
            asm_q    <= 32'h0;
            if (legal) begin
              state <= ACCESS;
              busy  <= 1'b1;
            end else begin
              state        <= DONE;
              done         <= 1'b1;
              misalign_err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt   <= cnt + 2'd1;
          asm_q <= assembled;
          if (cnt == last_idx) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            misalign_err <= 1'b0;
            if (!rw_q) data_out <= ext;
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b0;
          misalign_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads, stores, misalignment,
// reset abort and ignored inputs during an access.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable, mem_rw, mem_se;
  logic [1:0]  mem_size;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy, done, misalign_err;
  logic        load_we;
  logic [8:0]  load_addr;
  logic [7:0]  load_data;

  int tests = 0;
  int fails = 0;

  data_mem_responder #(.ADDR_W(9), .DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se),
    .address(address), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .misalign_err(misalign_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Issue one request and follow it to its done pulse (bounded wait).
  task automatic req(input logic rw, input logic [1:0] sz, input logic se,
                     input logic [8:0] a, input logic [31:0] din,
                     input bit disturb, input bit lwe,
                     output logic [31:0] dout, output int bcyc, output logic err);
    bit got;
    got = 0; bcyc = 0; dout = 'x; err = 'x;
    @(negedge clk);
    mem_enable = 1'b1; mem_rw = rw; mem_size = sz; mem_se = se;
    address = a; data_in = din;
    if (lwe) begin load_we = 1'b1; load_addr = 9'd13; load_data = 8'h77; end
    @(negedge clk);
    mem_enable = 1'b0; load_we = 1'b0;
    if (disturb) begin
      mem_enable = 1'b1; mem_size = 2'b00; address = 9'd0;
      load_we = 1'b1; load_addr = 9'd12; load_data = 8'h99;
    end
    for (int k = 0; k < 12 && !got; k++) begin
      if (done) begin
        got = 1; dout = data_out; err = misalign_err;
      end else begin
        if (busy) bcyc++;
        @(negedge clk);
        mem_enable = 1'b0; load_we = 1'b0;
      end
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    if (got) begin
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("busy_after_done", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] sz, input logic se,
                    input logic [8:0] a, input logic [31:0] exp, input int exp_busy);
    logic [31:0] d; int b; logic e;
    req(1'b0, sz, se, a, 32'h0, 1'b0, 1'b0, d, b, e);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_busy"}, b, exp_busy);
    chk({tag, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [1:0] sz, input logic [8:0] a,
                    input logic [31:0] din, input int exp_busy);
    logic [31:0] d; int b; logic e;
    req(1'b1, sz, 1'b1, a, din, 1'b0, 1'b0, d, b, e);
    chk({tag, "_data"}, d, 32'h0);
    chk({tag, "_busy"}, b, exp_busy);
    chk({tag, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic bad(input string tag, input logic rw, input logic [1:0] sz, input logic [8:0] a);
    logic [31:0] d; int b; logic e;
    req(rw, sz, 1'b0, a, 32'hFFFF_FFFF, 1'b0, 1'b0, d, b, e);
    chk({tag, "_data"}, d, 32'h0);
    chk({tag, "_busy"}, b, 0);
    chk({tag, "_err"}, {31'b0, e}, 32'd1);
  endtask

  initial begin
    logic [31:0] d; int b; logic e;
    reset = 1'b1; mem_enable = 1'b0; mem_rw = 1'b0; mem_size = 2'b00; mem_se = 1'b0;
    address = '0; data_in = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err",  {31'b0, misalign_err}, 32'd0);
    chk("rst_data", data_out, 32'h0);
    reset = 1'b0;

    preload(9'd0, 8'h84); preload(9'd1, 8'h22); preload(9'd2, 8'h33); preload(9'd3, 8'hF0);
    rd("w0", 2'b10, 1'b0, 9'd0, 32'h842233F0, 4);
    repeat (3) @(negedge clk);
    chk("data_held", data_out, 32'h842233F0);

    rd("h0_se",  2'b01, 1'b1, 9'd0, 32'hFFFF8422, 2);
    rd("h0_ze",  2'b01, 1'b0, 9'd0, 32'h00008422, 2);
    rd("b3_se",  2'b00, 1'b1, 9'd3, 32'hFFFFFFF0, 1);
    rd("b1_se",  2'b00, 1'b1, 9'd1, 32'h00000022, 1);

    wr("bw1", 2'b00, 9'd1, 32'h000000AB, 1);
    rd("w0_after_bw", 2'b10, 1'b0, 9'd0, 32'h84AB33F0, 4);
    wr("ww4", 2'b10, 9'd4, 32'hDEADBEEF, 4);
    rd("b5_ze", 2'b00, 1'b0, 9'd5, 32'h000000AD, 1);
    rd("h6_ze", 2'b01, 1'b0, 9'd6, 32'h0000BEEF, 2);

    bad("mis_w2",  1'b1, 2'b10, 9'd2);
    bad("mis_h1",  1'b0, 2'b01, 9'd1);
    bad("size11",  1'b1, 2'b11, 9'd0);
    rd("w0_unchanged", 2'b10, 1'b0, 9'd0, 32'h84AB33F0, 4);

    // Reset after two ACCESS edges of a word store at 8.
    preload(9'd8, 8'hAA); preload(9'd9, 8'hBB); preload(9'd10, 8'h55); preload(9'd11, 8'h66);
    @(negedge clk);
    mem_enable = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; address = 9'd8; data_in = 32'h01020304;
    @(negedge clk);
    mem_enable = 1'b0;
    chk("abort_busy_up", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_err",  {31'b0, misalign_err}, 32'd0);
    chk("abort_data", data_out, 32'h0);
    @(negedge clk);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    rd("ab8",  2'b00, 1'b0, 9'd8,  32'h01, 1);
    rd("ab9",  2'b00, 1'b0, 9'd9,  32'h02, 1);
    rd("ab10", 2'b00, 1'b0, 9'd10, 32'h55, 1);
    rd("ab11", 2'b00, 1'b0, 9'd11, 32'h66, 1);

    // Inputs toggled mid-access must be ignored.
    preload(9'd12, 8'h11); preload(9'd13, 8'h22); preload(9'd14, 8'h33); preload(9'd15, 8'h44);
    req(1'b0, 2'b10, 1'b0, 9'd12, 32'h0, 1'b1, 1'b0, d, b, e);
    chk("dist_data", d, 32'h11223344);
    chk("dist_busy", b, 4);
    chk("dist_err",  {31'b0, e}, 32'd0);
    rd("dist_b12", 2'b00, 1'b0, 9'd12, 32'h11, 1);

    // Preload strobe alongside an accepted request is dropped.
    req(1'b0, 2'b00, 1'b0, 9'd13, 32'h0, 1'b0, 1'b1, d, b, e);
    chk("lwe_data", d, 32'h22);
    rd("lwe_b13", 2'b00, 1'b0, 9'd13, 32'h22, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
